// File: rtl/ita_package.sv
// Shared types and sizes for the ITA output writer.
// Vector geometry plus the writer's state and address types.
package ita_package;

  localparam int unsigned N  = 16;
  localparam int unsigned WI = 8;

  typedef logic [N-1:0][WI-1:0] requant_oup_t;

  localparam int unsigned OupBytes     = N * WI / 8;
  localparam int unsigned OwrAddrWidth = 32;

  typedef logic [OwrAddrWidth-1:0] owr_addr_t;

  typedef enum logic {
    Idle,
    Run
  } owr_state_e;

endpackage

// File: rtl/ita_output_writer_if.sv
// Control/address link between the writer FSM and its
// address generator.
interface ita_output_writer_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumWidth  = 16
) ();

  logic                 load;
  logic [AddrWidth-1:0] base;
  logic [AddrWidth-1:0] stride;
  logic [NumWidth-1:0]  rows;
  logic [NumWidth-1:0]  tiles;
  logic                 advance;
  logic                 last;
  logic [AddrWidth-1:0] addr;

  modport master (
    output load, base, stride,
    output rows, tiles, advance,
    input  last, addr
  );

  modport slave (
    input  load, base, stride,
    input  rows, tiles, advance,
    output last, addr
  );

endinterface

// File: rtl/ita_output_addr_gen.sv
// Incremental tile-major/row-minor address generator for the
// output writer: adds and compares only, no multiplier.
module ita_output_addr_gen
  import ita_package::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumWidth  = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  ita_output_writer_if.slave ag
);

  localparam logic [AddrWidth-1:0] TileStep =
    AddrWidth'(OupBytes);
  localparam logic [NumWidth-1:0] One = NumWidth'(1);

  logic [NumWidth-1:0]  r_rows;
  logic [NumWidth-1:0]  r_tiles;
  logic [NumWidth-1:0]  r_row_cnt;
  logic [NumWidth-1:0]  r_tile_cnt;
  logic [AddrWidth-1:0] r_stride;
  logic [AddrWidth-1:0] r_row_addr;
  logic [AddrWidth-1:0] r_tile_base;

  logic w_row_wrap;
  logic w_tile_last;

  assign w_row_wrap  = (r_row_cnt == r_rows - One);
  assign w_tile_last = (r_tile_cnt == r_tiles - One);

  assign ag.last = w_row_wrap && w_tile_last;
  assign ag.addr = r_row_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rows      <= '0;
      r_tiles     <= '0;
      r_row_cnt   <= '0;
      r_tile_cnt  <= '0;
      r_stride    <= '0;
      r_row_addr  <= '0;
      r_tile_base <= '0;
    end else if (ag.load) begin
      r_rows      <= ag.rows;
      r_tiles     <= ag.tiles;
      r_row_cnt   <= '0;
      r_tile_cnt  <= '0;
      r_stride    <= ag.stride;
      r_row_addr  <= ag.base;
      r_tile_base <= ag.base;
    end else if (ag.advance) begin
      if (w_row_wrap) begin
        // next tile starts one vector width right of this one
        r_row_cnt   <= '0;
        r_tile_cnt  <= r_tile_cnt + One;
        r_tile_base <= r_tile_base + TileStep;
        r_row_addr  <= r_tile_base + TileStep;
      end else begin
        r_row_cnt  <= r_row_cnt + One;
        r_row_addr <= r_row_addr + r_stride;
      end
    end
  end

endmodule

// File: rtl/ita_output_writer.sv
// Streams ITA output vectors into memory as single-beat writes
// through a one-entry output register.
module ita_output_writer
  import ita_package::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned NumWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] row_stride_i,
  input  logic [NumWidth-1:0]  num_rows_i,
  input  logic [NumWidth-1:0]  num_tiles_i,
  input  logic                 oup_valid_i,
  output logic                 oup_ready_o,
  input  requant_oup_t         oup_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [N*WI-1:0]      mem_wdata_o,
  output logic [N*WI/8-1:0]    mem_be_o,
  output logic                 mem_we_o,
  output logic                 busy_o,
  output logic                 done_o
);

  owr_state_e           r_state;
  logic                 r_req;
  logic                 r_done;
  logic                 r_last_acc;
  logic [AddrWidth-1:0] r_addr;
  logic [N*WI-1:0]      r_data;

  logic w_cfg_ok;
  logic w_ready;
  logic w_accept;
  logic w_grant;

  ita_output_writer_if #(
    .AddrWidth(AddrWidth),
    .NumWidth (NumWidth)
  ) w_ag ();

  ita_output_addr_gen #(
    .AddrWidth(AddrWidth),
    .NumWidth (NumWidth)
  ) u_addr_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ag    (w_ag.slave)
  );

  assign w_cfg_ok = (|num_rows_i) && (|num_tiles_i);
  assign w_grant  = r_req && mem_gnt_i;

  // output register frees up in the same cycle it is granted
  assign w_ready  = (r_state == Run) && !r_last_acc
                 && (!r_req || mem_gnt_i);
  assign w_accept = oup_valid_i && w_ready;

  assign w_ag.load    = (r_state == Idle) && start_i
                     && w_cfg_ok;
  assign w_ag.base    = base_addr_i;
  assign w_ag.stride  = row_stride_i;
  assign w_ag.rows    = num_rows_i;
  assign w_ag.tiles   = num_tiles_i;
  assign w_ag.advance = w_accept;

  assign oup_ready_o = w_ready;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_req;
  assign mem_be_o    = {(N*WI/8){r_req}};
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_req ? r_data : '0;
  assign busy_o      = (r_state == Run);
  assign done_o      = r_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= Idle;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_last_acc <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        Idle: begin
          if (start_i) begin
            if (w_cfg_ok) begin
              r_state    <= Run;
              r_last_acc <= 1'b0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        Run: begin
          if (w_accept) begin
            r_req  <= 1'b1;
            r_addr <= w_ag.addr;
            r_data <= oup_i;
            if (w_ag.last) r_last_acc <= 1'b1;
          end else if (w_grant) begin
            r_req <= 1'b0;
            if (r_last_acc) begin
              r_state    <= Idle;
              r_done     <= 1'b1;
              r_last_acc <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ita_output_writer.sv
// Directed bench for ita_output_writer: basic job, stall,
// zero size, wrap-around, mid-job reset and restart attempt.
module tb_ita_output_writer;
  import ita_package::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  owr_addr_t    base_addr_i;
  owr_addr_t    row_stride_i;
  logic [15:0]  num_rows_i;
  logic [15:0]  num_tiles_i;
  logic         oup_valid_i;
  logic         oup_ready_o;
  requant_oup_t oup_i;
  logic         mem_req_o;
  logic         mem_gnt_i;
  owr_addr_t    mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [15:0]  mem_be_o;
  logic         mem_we_o;
  logic         busy_o;
  logic         done_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ita_output_writer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .row_stride_i(row_stride_i),
    .num_rows_i  (num_rows_i),
    .num_tiles_i (num_tiles_i),
    .oup_valid_i (oup_valid_i),
    .oup_ready_o (oup_ready_o),
    .oup_i       (oup_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_we_o    (mem_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] vec(input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 | 32'(k);
    return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'h11};
  endfunction

  function automatic owr_addr_t exp_addr(
    input owr_addr_t base, input owr_addr_t stride,
    input int rows, input int g);
    owr_addr_t t, r;
    t = owr_addr_t'(g / rows);
    r = owr_addr_t'(g % rows);
    return base + r * stride + t * 32'd16;
  endfunction

  task automatic outputs_zero(input string tag);
    chk({tag, "_req"},   128'(mem_req_o),   '0);
    chk({tag, "_we"},    128'(mem_we_o),    '0);
    chk({tag, "_be"},    128'(mem_be_o),    '0);
    chk({tag, "_wdata"}, mem_wdata_o,       '0);
    chk({tag, "_addr"},  128'(mem_addr_o),  '0);
    chk({tag, "_ready"}, 128'(oup_ready_o), '0);
    chk({tag, "_busy"},  128'(busy_o),      '0);
    chk({tag, "_done"},  128'(done_o),      '0);
  endtask

  task automatic run_job(
    input string tag,
    input owr_addr_t base, input owr_addr_t stride,
    input int rows, input int tiles,
    input int stall_at, input int stall_n,
    input bit restart);
    int g = 0;
    int s = 0;
    int cyc = 0;
    int stalls = 0;
    int total;
    bit hs;
    owr_addr_t    held_a;
    logic [127:0] held_d;
    total = rows * tiles;
    base_addr_i  = base;
    row_stride_i = stride;
    num_rows_i   = 16'(rows);
    num_tiles_i  = 16'(tiles);
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, "_busy_on"}, 128'(busy_o), 128'd1);
    while (g < total && cyc < 200) begin
      oup_valid_i = 1'b1;
      oup_i       = vec(s);
      if (restart && cyc == 1) begin
        start_i      = 1'b1;
        base_addr_i  = 32'hDEAD0000;
        row_stride_i = 32'h4;
        num_rows_i   = 16'd1;
        num_tiles_i  = 16'd1;
      end else begin
        start_i = 1'b0;
      end
      if (mem_req_o && g == stall_at && stalls < stall_n)
        mem_gnt_i = 1'b0;
      else
        mem_gnt_i = 1'b1;
      #1;
      if (!mem_gnt_i) begin
        if (stalls == 0) begin
          held_a = mem_addr_o;
          held_d = mem_wdata_o;
        end else begin
          chk({tag, "_stall_addr"}, 128'(mem_addr_o),
              128'(held_a));
          chk({tag, "_stall_data"}, mem_wdata_o, held_d);
        end
        chk({tag, "_stall_rdy"}, 128'(oup_ready_o), '0);
        stalls++;
      end
      if (mem_req_o && mem_gnt_i) begin
        chk({tag, "_addr"}, 128'(mem_addr_o),
            128'(exp_addr(base, stride, rows, g)));
        chk({tag, "_data"}, mem_wdata_o, vec(g));
        chk({tag, "_we"}, 128'(mem_we_o), 128'd1);
        chk({tag, "_be"}, 128'(mem_be_o), 128'hFFFF);
        g++;
      end
      hs = oup_valid_i && oup_ready_o;
      step();
      if (hs) s++;
      cyc++;
    end
    start_i     = 1'b0;
    oup_valid_i = 1'b0;
    mem_gnt_i   = 1'b0;
    chk({tag, "_grants"}, 128'(g), 128'(total));
    chk({tag, "_accepts"}, 128'(s), 128'(total));
    chk({tag, "_done"}, 128'(done_o), 128'd1);
    chk({tag, "_idle"}, 128'(busy_o), '0);
    chk({tag, "_req_off"}, 128'(mem_req_o), '0);
    chk({tag, "_wd_off"}, mem_wdata_o, '0);
    step();
    chk({tag, "_done_pulse"}, 128'(done_o), '0);
  endtask

  initial begin
    int g;
    int cyc;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = '0;
    row_stride_i = '0;
    num_rows_i   = '0;
    num_tiles_i  = '0;
    oup_valid_i  = 1'b0;
    oup_i        = '0;
    mem_gnt_i    = 1'b0;
    step();
    step();
    outputs_zero("reset");
    rst_ni = 1'b1;
    step();

    // basic job, grant tied high
    run_job("basic", 32'h1000, 32'h40, 2, 2, -1, 0, 1'b0);

    // grant withheld three cycles on vector 1
    run_job("stall", 32'h1000, 32'h40, 2, 2, 1, 3, 1'b0);

    // zero-size job
    base_addr_i = 32'h5000;
    num_rows_i  = 16'd0;
    num_tiles_i = 16'd3;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    chk("zero_done", 128'(done_o), 128'd1);
    chk("zero_busy", 128'(busy_o), '0);
    chk("zero_req", 128'(mem_req_o), '0);
    step();
    chk("zero_done_pulse", 128'(done_o), '0);
    chk("zero_busy2", 128'(busy_o), '0);
    chk("zero_req2", 128'(mem_req_o), '0);

    // address wraps modulo 2^32
    run_job("wrap", 32'hFFFF_FFF0, 32'h10, 2, 1, -1, 0,
            1'b0);

    // reset after 3 of 8 vectors
    base_addr_i  = 32'h2000;
    row_stride_i = 32'h20;
    num_rows_i   = 16'd4;
    num_tiles_i  = 16'd2;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    g   = 0;
    cyc = 0;
    while (g < 3 && cyc < 50) begin
      oup_valid_i = 1'b1;
      oup_i       = vec(g + 1);
      mem_gnt_i   = 1'b1;
      #1;
      if (mem_req_o && mem_gnt_i) g++;
      step();
      cyc++;
    end
    chk("mid_grants", 128'(g), 128'd3);
    chk("mid_busy", 128'(busy_o), 128'd1);
    rst_ni = 1'b0;
    #1;
    outputs_zero("mid_rst");
    step();
    outputs_zero("mid_rst2");
    oup_valid_i = 1'b0;
    mem_gnt_i   = 1'b0;
    rst_ni      = 1'b1;
    step();
    chk("mid_post_done", 128'(done_o), '0);
    chk("mid_post_busy", 128'(busy_o), '0);
    step();
    chk("mid_post_done2", 128'(done_o), '0);
    run_job("after_rst", 32'h3000, 32'h80, 2, 2, -1, 0,
            1'b0);

    // second start while running is ignored
    run_job("restart", 32'h4000, 32'h100, 2, 2, -1, 0,
            1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ita_output_writer.md
ITA_OUTPUT_WRITER -- requirements
Module: ita_output_writer

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, giving the memory byte-address width.
REQ-002 SHALL have parameter NumWidth, default 16, giving the width of the row and tile count inputs.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_i, input, 1 bit: clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle job start.
REQ-007 SHALL have port base_addr_i, input, AddrWidth bits: byte address of output element (0,0).
REQ-008 SHALL have port row_stride_i, input, AddrWidth bits: byte distance between consecutive rows.
REQ-009 SHALL have port num_rows_i, input, NumWidth bits: rows per tile.
REQ-010 SHALL have port num_tiles_i, input, NumWidth bits: column tiles per job.
REQ-011 SHALL have port oup_valid_i, input, 1 bit: an ITA output vector is valid.
REQ-012 SHALL have port oup_ready_o, output, 1 bit: the block accepts the vector.
REQ-013 SHALL have port oup_i, input, N*WI bits: the ITA output vector (requant_oup_t).
REQ-014 SHALL have port mem_req_o, output, 1 bit: memory write request.
REQ-015 SHALL have port mem_gnt_i, input, 1 bit: memory grant.
REQ-016 SHALL have port mem_addr_o, output, AddrWidth bits: byte address.
REQ-017 SHALL have port mem_wdata_o, output, N*WI bits: write data.
REQ-018 SHALL have port mem_be_o, output, N*WI/8 bits: byte enables.
REQ-019 SHALL have port mem_we_o, output, 1 bit: write enable.
REQ-020 SHALL have port busy_o, output, 1 bit: a job is active.
REQ-021 SHALL have port done_o, output, 1 bit: single-cycle job-complete pulse.

Function
REQ-022 SHALL implement the FSM states Idle and Run.
REQ-023 In Idle, start_i with nonzero num_rows_i and num_tiles_i SHALL latch all configuration inputs, clear the counters and enter Run.
REQ-024 In Idle, start_i with num_rows_i==0 or num_tiles_i==0 SHALL pulse done_o on the next cycle and remain in Idle.
REQ-025 start_i SHALL be ignored while in Run.
REQ-026 Vectors SHALL be written in this order: tile-major, then row.
REQ-027 The address of vector (tile t, row r) SHALL be base + r*row_stride + t*(N*WI/8), computed modulo 2^AddrWidth.
REQ-028 The address SHALL be computed incrementally using a row-address accumulator and a tile-base register; no multiplier SHALL be used.
REQ-029 An input handshake (oup_valid_i && oup_ready_o) SHALL load a one-entry output register, so that mem_req_o is high with that vector in the following cycle (1-cycle latency).
REQ-030 oup_ready_o SHALL equal Run && !last_accepted && (!mem_req_o || mem_gnt_i), giving full throughput under a continuous grant.
REQ-031 While mem_req_o is high and mem_gnt_i is low, mem_addr_o and mem_wdata_o SHALL stay stable.
REQ-032 mem_req_o SHALL deassert after a grant unless a new vector is loaded in the same cycle.
REQ-033 mem_we_o SHALL be 1 and mem_be_o SHALL be all ones whenever mem_req_o is high.
REQ-034 mem_we_o and mem_be_o SHALL be 0 otherwise.
REQ-035 mem_wdata_o SHALL be 0 when mem_req_o is low.
REQ-036 When the row counter wraps to 0, the tile counter SHALL increment and the row accumulator SHALL reload with tile_base + N*WI/8.
REQ-037 After the last vector is accepted, oup_ready_o SHALL stay low.
REQ-038 On the grant of the last vector, the block SHALL return to Idle and pulse done_o in the next cycle.
REQ-039 busy_o SHALL be high exactly while in Run.

Reset
REQ-040 Reset SHALL force the FSM to Idle.
REQ-041 Reset SHALL clear all counters, configuration registers and the output register.
REQ-042 During reset, mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o, oup_ready_o, busy_o and done_o SHALL all be 0.
REQ-043 Reset asserted mid-job SHALL abandon the job immediately, including any pending request, and SHALL NOT produce a done_o pulse.

Structure
REQ-044 N, WI and requant_oup_t SHALL come from ita_package.
REQ-045 ita_package SHALL add the typedefs owr_state_e (Idle, Run) and owr_addr_t.
REQ-046 The address generator SHALL be a separate sub-module, ita_output_addr_gen, holding the row and tile counters and the accumulators, with an advance input and last/addr outputs.

Verification
REQ-047 Basic job: N=16, WI=8, base=0x1000, stride=0x40, rows=2, tiles=2, grant tied high -> addresses 0x1000, 0x1040, 0x1010, 0x1050 on consecutive cycles, done_o one cycle after the 4th grant.
REQ-048 Backpressure: the grant is held low for 3 cycles on vector 1 -> mem_addr_o and mem_wdata_o stay stable, oup_ready_o stays low, and no vector is lost or duplicated.
REQ-049 Zero size: start with rows=0 -> done_o pulses on the next cycle, busy_o never rises, and mem_req_o stays 0.
REQ-050 Wrap-around: base=0xFFFF_FFF0, stride=0x10, rows=2, tiles=1 -> addresses 0xFFFF_FFF0, 0x0000_0000.
REQ-051 Reset mid-job: rst_ni is pulsed low after 3 of 8 vectors -> all outputs are 0, there is no done_o, and a subsequent job runs correctly from its base.
REQ-052 start_i during Run: start_i is asserted again with different configuration -> the configuration is ignored, and the addresses follow the original job.
